// File: rtl/summ_frame.sv
`timescale 1ns/1ps
// Frame accumulator: sums N gated (or sign-selected) signed terms with saturate/wrap, then pulses oValid.
// Latency: oSum updates one cycle after acceptance; oValid the cycle after the N-th term. No backpressure: terms are taken whenever iValid is high in ACC.
module summ_frame #(
    parameter int W       = 3,
    parameter int N       = 8,
    parameter int SAT     = 1,
    parameter int BIPOLAR = 0
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iStart,
    input  logic                iValid,
    input  logic                iBitU,
    input  logic signed [W-1:0] iTerm,
    output logic signed [W-1:0] oSum,
    output logic                oValid,
    output logic                oSat,
    output logic                oBusy
);

    localparam int CW = $clog2(N + 1);
    localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};

    // One bit per active state so oBusy/oValid come straight from flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state, stateNxt;
    logic [CW-1:0]       count, countNxt;
    logic signed [W-1:0] sumNxt;
    logic                satNxt;

    logic signed [W+1:0] sumExt, termExt, addend, result;
    logic signed [W-1:0] reduced;
    logic                ovf;

    always_comb begin
        sumExt  = {{2{oSum[W-1]}}, oSum};
        termExt = {{2{iTerm[W-1]}}, iTerm};
        if (iBitU)
            addend = termExt;
        else if (BIPOLAR != 0)
            addend = -termExt;
        else
            addend = '0;
        result = sumExt + addend;
        ovf    = (result > MAXV) || (result < MINV);
        reduced = result[W-1:0];
        if (SAT != 0) begin
            if (result > MAXV)
                reduced = MAXV[W-1:0];
            else if (result < MINV)
                reduced = MINV[W-1:0];
        end
    end

    always_comb begin
        stateNxt = state;
        sumNxt   = oSum;
        satNxt   = oSat;
        countNxt = count;
        case (state)
            IDLE: begin
                if (iStart) begin
                    sumNxt   = '0;
                    satNxt   = 1'b0;
                    countNxt = '0;
                    stateNxt = ACC;
                end
            end
            ACC: begin
                // A restart wins over a term arriving in the same cycle.
                if (iStart) begin
                    sumNxt   = '0;
                    satNxt   = 1'b0;
                    countNxt = '0;
                end else if (iValid) begin
                    sumNxt   = reduced;
                    satNxt   = oSat | ovf;
                    countNxt = count + CW'(1);
                    if (count == CW'(N - 1))
                        stateNxt = DONE;
                end
            end
            DONE: begin
                if (iStart) begin
                    sumNxt   = '0;
                    satNxt   = 1'b0;
                    countNxt = '0;
                    stateNxt = ACC;
                end else begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
            oSum  <= '0;
            oSat  <= 1'b0;
            count <= '0;
        end else begin
            state <= stateNxt;
            oSum  <= sumNxt;
            oSat  <= satNxt;
            count <= countNxt;
        end
    end

    assign oBusy  = state[0];
    assign oValid = state[1];

endmodule

// File: tb/tb_summ_frame.sv
`timescale 1ns/1ps
// Four parameter corners (SAT x BIPOLAR) driven by shared directed vectors; frame results scoreboarded on oValid.
module tb_summ_frame;

    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    logic iStart = 1'b0;
    logic iValid = 1'b0;
    logic iBitU = 1'b0;
    logic signed [2:0] iTerm = '0;

    logic signed [2:0] sum [4];
    logic [3:0] vld, sat, busy;

    int nChk = 0;
    int nErr = 0;

    typedef struct {
        int s [4];
        int t [4];
    } exp_t;
    exp_t q[$];

    always #5 iClk = ~iClk;

    // 0: SAT=1 BIP=0   1: SAT=0 BIP=0   2: SAT=1 BIP=1   3: SAT=0 BIP=1
    summ_frame #(.W(3), .N(4), .SAT(1), .BIPOLAR(0)) dutA (.iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
        .iValid(iValid), .iBitU(iBitU), .iTerm(iTerm), .oSum(sum[0]), .oValid(vld[0]), .oSat(sat[0]), .oBusy(busy[0]));
    summ_frame #(.W(3), .N(4), .SAT(0), .BIPOLAR(0)) dutB (.iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
        .iValid(iValid), .iBitU(iBitU), .iTerm(iTerm), .oSum(sum[1]), .oValid(vld[1]), .oSat(sat[1]), .oBusy(busy[1]));
    summ_frame #(.W(3), .N(4), .SAT(1), .BIPOLAR(1)) dutC (.iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
        .iValid(iValid), .iBitU(iBitU), .iTerm(iTerm), .oSum(sum[2]), .oValid(vld[2]), .oSat(sat[2]), .oBusy(busy[2]));
    summ_frame #(.W(3), .N(4), .SAT(0), .BIPOLAR(1)) dutD (.iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
        .iValid(iValid), .iBitU(iBitU), .iTerm(iTerm), .oSum(sum[3]), .oValid(vld[3]), .oSat(sat[3]), .oBusy(busy[3]));

    task automatic chk(input string nm, input int act, input int exp);
        nChk++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkSum(input string nm, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s sum dut%0d", nm, d), int'(sum[d]), e[d]);
    endtask

    task automatic chkSat(input string nm, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s sat dut%0d", nm, d), int'(sat[d]), e[d]);
    endtask

    task automatic push(input int s0, input int s1, input int s2, input int s3,
                        input int t0, input int t1, input int t2, input int t3);
        exp_t e;
        e.s[0] = s0; e.s[1] = s1; e.s[2] = s2; e.s[3] = s3;
        e.t[0] = t0; e.t[1] = t1; e.t[2] = t2; e.t[3] = t3;
        q.push_back(e);
    endtask

    // Apply one cycle of inputs; returns just after the capturing edge.
    task automatic step(input logic st, input logic v, input logic b, input int t);
        @(negedge iClk);
        iStart = st;
        iValid = v;
        iBitU  = b;
        iTerm  = 3'(t);
        @(posedge iClk);
        #1;
    endtask

    always @(negedge iClk) begin
        if (vld != 4'b0000) begin
            if (q.size() == 0) begin
                chk("unexpected oValid", int'(vld), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                for (int d = 0; d < 4; d++) begin
                    chk($sformatf("frame valid dut%0d", d), int'(vld[d]), 1);
                    chk($sformatf("frame sum dut%0d", d), int'(sum[d]), e.s[d]);
                    chk($sformatf("frame sat dut%0d", d), int'(sat[d]), e.t[d]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chkSum("reset", 0, 0, 0, 0);
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(vld), 0);
        chk("reset sat", int'(sat), 0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;

        // Saturate vs wrap on 3+3
        push(3, -2, 3, -2, 1, 1, 1, 1);
        step(1, 0, 0, 0);
        chk("start busy", int'(busy), 4'hF);
        step(0, 1, 1, 3);
        chkSum("t1 first", 3, 3, 3, 3);
        chkSat("t1 first", 0, 0, 0, 0);
        step(0, 1, 1, 3);
        chkSum("t1 second", 3, -2, 3, -2);
        chkSat("t1 second", 1, 1, 1, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("t1 done valid", int'(vld), 4'hF);
        chk("t1 done busy", int'(busy), 0);
        step(0, 0, 0, 0);
        chk("t1 idle valid", int'(vld), 0);
        chkSum("t1 hold", 3, -2, 3, -2);

        // Gated vs bipolar bit pattern 1,0,1,1
        push(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        chkSat("t2 start clears", 0, 0, 0, 0);
        chkSum("t2 start clears", 0, 0, 0, 0);
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        chkSum("t2 after 2", 1, 1, 0, 0);
        step(0, 1, 1, 1);
        step(0, 1, 1, -1);
        chk("t2 done valid", int'(vld), 4'hF);
        step(0, 0, 0, 0);
        chk("t2 single pulse", int'(vld), 0);

        // Negating the most negative term
        push(0, 0, 3, -4, 0, 0, 1, 1);
        step(1, 0, 0, 0);
        step(0, 1, 0, -4);
        chkSum("t3 neg min", 0, 0, 3, -4);
        chkSat("t3 neg min", 0, 0, 1, 1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);

        // Abort with a colliding term, gaps, then restart from DONE
        push(-4, 3, -4, 2, 1, 1, 1, 1);
        step(1, 0, 0, 0);
        step(0, 1, 1, 2);
        step(0, 1, 1, 1);
        chkSum("t4 pre-abort", 3, 3, 3, 3);
        step(1, 1, 1, 3);
        chkSum("t4 abort", 0, 0, 0, 0);
        chk("t4 abort busy", int'(busy), 4'hF);
        step(0, 0, 1, 3);
        chkSum("t4 gap hold", 0, 0, 0, 0);
        step(0, 1, 1, -1);
        step(0, 0, 0, 2);
        step(0, 1, 1, -2);
        chkSum("t4 after gap", -3, -3, -3, -3);
        step(0, 1, 0, 1);
        chkSum("t4 third", -3, -3, -4, -4);
        chk("t4 third busy", int'(busy), 4'hF);
        chk("t4 third valid", int'(vld), 0);
        step(0, 1, 1, -2);
        chk("t4 done valid", int'(vld), 4'hF);
        step(1, 0, 0, 0);
        chk("t4 restart busy", int'(busy), 4'hF);
        chk("t4 restart valid", int'(vld), 0);
        chkSum("t4 restart", 0, 0, 0, 0);

        // Asynchronous reset mid-frame
        step(0, 1, 1, 3);
        step(0, 1, 1, 3);
        chkSat("t5 pre-reset", 1, 1, 1, 1);
        @(negedge iClk);
        iValid = 1'b0;
        #2 iRst_n = 1'b0;
        #1;
        chkSum("t5 reset", 0, 0, 0, 0);
        chk("t5 reset sat", int'(sat), 0);
        chk("t5 reset busy", int'(busy), 0);
        chk("t5 reset valid", int'(vld), 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        chkSum("t5 no start", 0, 0, 0, 0);
        chk("t5 no start busy", int'(busy), 0);
        step(0, 0, 0, 0);
        repeat (3) @(negedge iClk);
        #1;
        chk("frames outstanding", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule

// File: doc/summ_frame.md
SUMM_FRAME -- requirements
Module: summ_frame

Interface
REQ-001 Parameter W, default 3: signed term and sum width, W >= 2.
REQ-002 Parameter N, default 8: terms per frame, N >= 2.
REQ-003 Parameter SAT, default 1: 1 = saturating arithmetic, 0 = two's-complement wrap.
REQ-004 Parameter BIPOLAR, default 0: 0 = iBitU=0 skips the term, 1 = iBitU=0 subtracts the term.
REQ-005 One clock; reset is asynchronous and active-low; ports iClk and iRst_n.
REQ-006 iClk  input  1  clock; all state changes on its rising edge.
REQ-007 iRst_n  input  1  asynchronous active-low reset.
REQ-008 iStart  input  1  begin a new frame; clears the accumulator.
REQ-009 iValid  input  1  iBitU and iTerm are valid this cycle.
REQ-010 iBitU  input  1  gating/sign bit for the current term.
REQ-011 iTerm  input  W  signed term.
REQ-012 oSum  output  W  signed running sum, registered.
REQ-013 oValid  output  1  one-cycle pulse: frame complete, oSum is final.
REQ-014 oSat  output  1  sticky per frame: at least one clip or wrap occurred.
REQ-015 oBusy  output  1  high while in ACC.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACC and DONE, with IDLE as the reset state.
REQ-017 IDLE: iStart=1 -> oSum<=0, oSat<=0, count<=0, next ACC; otherwise hold; iValid ignored.
REQ-018 ACC, iValid=1: BIPOLAR=0 -> sum+iTerm if iBitU=1, else sum unchanged; BIPOLAR=1 -> sum+iTerm if iBitU=1, else sum-iTerm; count<=count+1.
REQ-019 ACC, iValid=0: sum, count and oSat hold.
REQ-020 Arithmetic SHALL use W+2 bits internally; the result is reduced to W bits before registering.
REQ-021 SAT=1: clip to [-2^(W-1), 2^(W-1)-1]; SAT=0: keep the low W bits.
REQ-022 oSat SHALL set when the W+2-bit result lies outside the W-bit range, in either SAT mode.
REQ-023 Negating -2^(W-1) (BIPOLAR=1, iBitU=0) SHALL be treated as overflow per REQ-021/022.
REQ-024 The accepted term that makes count reach N SHALL also move the FSM to DONE in the same edge.
REQ-025 DONE lasts exactly one cycle with oValid=1, then IDLE; oSum and oSat hold until the next iStart.
REQ-026 Latency: oSum reflects an accepted term on the cycle after acceptance; oValid asserts the cycle after the N-th accepted term.
REQ-027 iStart in ACC SHALL abort the frame: oSum<=0, oSat<=0, count<=0, stay ACC; a simultaneous iValid term is discarded.
REQ-028 iStart in DONE SHALL be honoured as in IDLE (next ACC), with oValid still 1 in that cycle.
REQ-029 oBusy SHALL be 1 exactly when the state is ACC.
REQ-030 The counter SHALL be ceil(log2(N+1)) bits and never wrap within a frame.

Reset
REQ-031 iRst_n=0 SHALL immediately force state IDLE, oSum=0, oValid=0, oSat=0, oBusy=0 and count=0, independent of iClk.
REQ-032 Reset mid-frame SHALL discard the frame; after release the block waits for iStart.
REQ-033 Release of iRst_n SHALL take effect at the next rising iClk edge; no output glitches.

Verification (W=3, N=4 unless stated)
REQ-034 SAT=1, BIPOLAR=0: iStart, terms 3,3 with iBitU=1 -> oSum 3 then 3, oSat=1.
REQ-035 SAT=0: terms 3,3 with iBitU=1 -> oSum 3 then -2 (110), oSat=1.
REQ-036 BIPOLAR=0, terms 1,1,1,-1 with bits 1,0,1,1 -> final oSum=1, oValid pulses once, the cycle after the 4th term; oSat=0.
REQ-037 BIPOLAR=1, SAT=1: term -4 with iBitU=0 -> oSum=3, oSat=1; with SAT=0 -> oSum=-4, oSat=1.
REQ-038 Two terms accepted, iStart asserted with iValid=1 -> oSum=0, count restarts, 4 new terms required before oValid; iValid gaps hold state.
REQ-039 Reset asserted mid-frame, between clock edges -> all outputs 0 at once; after release, terms without iStart leave oSum=0 and oBusy=0.
